// File: rtl/neopixel_frame_ctrl.sv
// rtl/neopixel_frame_ctrl.sv - NeoPixel frame sequencer: pixel fetch, GRB bit strobes, latch timing
module neopixel_frame_ctrl #(
    parameter int NUM_PIXELS = 8,
    parameter int CLK_HZ     = 12_000_000,
    parameter int LATCH_US   = 60,
    localparam int AW        = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          start,
    output logic [AW-1:0] px_addr,
    input  logic [23:0]   px_data,
    output logic          bit_value,
    output logic          bit_valid,
    input  logic          bit_busy,
    output logic          frame_busy,
    output logic          frame_done
);

    localparam int LATCH_CYCLES = (CLK_HZ / 1_000_000) * LATCH_US;
    localparam int LW           = $clog2(LATCH_CYCLES + 1);

    localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);
    localparam logic [AW-1:0] LAST_PX    = AW'(NUM_PIXELS - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] LOAD      = 3'd2;
    localparam logic [2:0] SEND      = 3'd3;
    localparam logic [2:0] WAIT_ACK  = 3'd4;
    localparam logic [2:0] WAIT_DONE = 3'd5;
    localparam logic [2:0] LATCH     = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [23:0]   shift_q, shift_d;
    logic [4:0]    bcnt_q, bcnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // The pixel index doubles as the read address, so it naturally holds outside FETCH.
    assign px_addr    = idx_q;
    assign bit_value  = shift_q[23];
    assign bit_valid  = (state_q == SEND);
    assign frame_busy = busy_q;
    assign frame_done = done_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        bcnt_d  = bcnt_q;
        lcnt_d  = lcnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                shift_d = px_data;
                bcnt_d  = 5'd0;
                state_d = SEND;
            end
            SEND: state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (bit_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bit_busy) begin
                    bcnt_d = bcnt_q + 5'd1;
                    // The last bit is not shifted out so bit_value keeps its level until the next pixel loads.
                    if (bcnt_q == 5'd23) begin
                        if (idx_q == LAST_PX) begin
                            state_d = LATCH;
                            lcnt_d  = '0;
                        end else begin
                            idx_d   = idx_q + AW'(1);
                            state_d = FETCH;
                        end
                    end else begin
                        shift_d = {shift_q[22:0], 1'b0};
                        state_d = SEND;
                    end
                end
            end
            LATCH: begin
                if (lcnt_q == LATCH_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    lcnt_d = lcnt_q + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            bcnt_q  <= '0;
            lcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            lcnt_q  <= lcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_neopixel_frame_ctrl.sv
// tb/tb_neopixel_frame_ctrl.sv - directed bench: 2-pixel and 1-pixel controllers with a bit-writer model
module tb_neopixel_frame_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST_N, start_a, start_b, hold;
    logic [0:0]  px_addr_a, px_addr_b;
    logic [23:0] px_data_a, px_data_b;
    logic        bv_a, bvl_a, busy_a, fb_a, fd_a;
    logic        bv_b, bvl_b, busy_b, fb_b, fd_b;

    int vectors = 0, miscompares = 0;

    neopixel_frame_ctrl #(.NUM_PIXELS(2)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .start(start_a), .px_addr(px_addr_a), .px_data(px_data_a),
        .bit_value(bv_a), .bit_valid(bvl_a), .bit_busy(busy_a), .frame_busy(fb_a), .frame_done(fd_a));

    neopixel_frame_ctrl #(.NUM_PIXELS(1)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .start(start_b), .px_addr(px_addr_b), .px_data(px_data_b),
        .bit_value(bv_b), .bit_valid(bvl_b), .bit_busy(busy_b), .frame_busy(fb_b), .frame_done(fd_b));

    // Pixel buffer with one-cycle read latency
    always @(posedge CLK) px_data_a <= (px_addr_a == 1'b1) ? 24'h00A5C3 : 24'hFF0000;
    assign px_data_b = 24'h000001;

    // Bit writer: busy for 8 cycles starting 2 cycles after a strobe; hold freezes it idle
    int wcnt_a, wcnt_b;
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wcnt_a <= 0;
            wcnt_b <= 0;
        end else begin
            if (wcnt_a == 0) begin
                if (bvl_a) wcnt_a <= 10;
            end else if (!hold) wcnt_a <= wcnt_a - 1;
            if (wcnt_b == 0) begin
                if (bvl_b) wcnt_b <= 10;
            end else wcnt_b <= wcnt_b - 1;
        end
    end
    assign busy_a = (wcnt_a >= 1) && (wcnt_a <= 8);
    assign busy_b = (wcnt_b >= 1) && (wcnt_b <= 8);

    int strobes_a = 0, dones_a = 0, gap_a = 0, last_gap_a = 0;
    int strobes_b = 0, dones_b = 0, gap_b = 0, last_gap_b = 0;
    logic [47:0] stream_a = '0;
    logic [23:0] stream_b = '0;
    always @(negedge CLK) begin
        if (bvl_a) begin
            strobes_a++;
            stream_a = {stream_a[46:0], bv_a};
            gap_a = 0;
        end else gap_a++;
        if (fd_a) begin
            dones_a++;
            last_gap_a = gap_a;
        end
        if (bvl_b) begin
            strobes_b++;
            stream_b = {stream_b[22:0], bv_b};
            gap_b = 0;
        end else gap_b++;
        if (fd_b) begin
            dones_b++;
            last_gap_b = gap_b;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_done(input bit sel);
        int d0;
        d0 = sel ? dones_b : dones_a;
        for (int i = 0; i < 3000; i++) begin
            step();
            if ((sel ? dones_b : dones_a) != d0) break;
        end
    endtask

    task automatic wait_strobes(input int s0, input int target);
        for (int i = 0; i < 1000; i++) begin
            if (strobes_a - s0 >= target) break;
            step();
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int s0, d0;

    initial begin
        RST_N = 1'b0; start_a = 1'b0; start_b = 1'b0; hold = 1'b0;
        repeat (3) step();
        check("rst_bit_valid", 64'(bvl_a), 64'd0);
        check("rst_bit_value", 64'(bv_a), 64'd0);
        check("rst_px_addr", 64'(px_addr_a), 64'd0);
        check("rst_frame_busy", 64'(fb_a), 64'd0);
        check("rst_frame_done", 64'(fd_a), 64'd0);
        check("rst_frame_busy_b", 64'(fb_b), 64'd0);

        // Start presented in the first cycle after reset release
        s0 = strobes_a; d0 = dones_a;
        RST_N = 1'b1; start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("post_rst_busy", 64'(fb_a), 64'd1);
        check("post_rst_fetch_addr", 64'(px_addr_a), 64'd0);
        check("post_rst_no_strobe", 64'(bvl_a), 64'd0);
        wait_done(1'b0);
        check("f1_done_count", 64'(dones_a - d0), 64'd1);
        check("f1_strobes", 64'(strobes_a - s0), 64'd48);
        check("f1_stream", 64'(stream_a), 64'hFF000000A5C3);
        check("f1_latch_gap", 64'(last_gap_a), 64'd732);
        check("f1_busy_at_done", 64'(fb_a), 64'd0);
        step();
        check("f1_done_pulse_width", 64'(fd_a), 64'd0);

        // Start re-pulsed at strobe 10 must be ignored
        s0 = strobes_a; d0 = dones_a;
        start_a = 1'b1; step(); start_a = 1'b0;
        wait_strobes(s0, 10);
        check("f2_reached_10", 64'(strobes_a - s0), 64'd10);
        start_a = 1'b1; step(); start_a = 1'b0;
        check("f2_busy_kept", 64'(fb_a), 64'd1);
        wait_done(1'b0);
        step();
        check("f2_strobes", 64'(strobes_a - s0), 64'd48);
        check("f2_done_count", 64'(dones_a - d0), 64'd1);
        check("f2_stream", 64'(stream_a), 64'hFF000000A5C3);

        // Writer stalls 50 cycles after the first strobe
        s0 = strobes_a; d0 = dones_a;
        start_a = 1'b1; step(); start_a = 1'b0;
        wait_strobes(s0, 1);
        hold = 1'b1;
        repeat (50) step();
        check("stall_single_strobe", 64'(strobes_a - s0), 64'd1);
        check("stall_writer_idle", 64'(busy_a), 64'd0);
        check("stall_frame_busy", 64'(fb_a), 64'd1);
        hold = 1'b0;
        wait_done(1'b0);
        check("stall_strobes", 64'(strobes_a - s0), 64'd48);
        check("stall_done_count", 64'(dones_a - d0), 64'd1);
        check("stall_stream", 64'(stream_a), 64'hFF000000A5C3);

        // Reset during pixel 1 bit 5 (strobe 30)
        s0 = strobes_a; d0 = dones_a;
        start_a = 1'b1; step(); start_a = 1'b0;
        wait_strobes(s0, 30);
        check("mid_reached_30", 64'(strobes_a - s0), 64'd30);
        check("mid_addr_pixel1", 64'(px_addr_a), 64'd1);
        RST_N = 1'b0;
        #1;
        check("mid_rst_bit_valid", 64'(bvl_a), 64'd0);
        check("mid_rst_bit_value", 64'(bv_a), 64'd0);
        check("mid_rst_px_addr", 64'(px_addr_a), 64'd0);
        check("mid_rst_frame_busy", 64'(fb_a), 64'd0);
        check("mid_rst_frame_done", 64'(fd_a), 64'd0);
        repeat (3) step();
        RST_N = 1'b1;
        repeat (200) step();
        check("mid_no_more_strobes", 64'(strobes_a - s0), 64'd30);
        check("mid_no_done", 64'(dones_a - d0), 64'd0);
        check("mid_idle_busy", 64'(fb_a), 64'd0);

        // Single-pixel controller
        s0 = strobes_b; d0 = dones_b;
        start_b = 1'b1; step(); start_b = 1'b0;
        check("np1_busy", 64'(fb_b), 64'd1);
        wait_done(1'b1);
        check("np1_done_count", 64'(dones_b - d0), 64'd1);
        check("np1_strobes", 64'(strobes_b - s0), 64'd24);
        check("np1_stream", 64'(stream_b), 64'h000001);
        check("np1_latch_gap", 64'(last_gap_b), 64'd732);
        check("np1_busy_at_done", 64'(fb_b), 64'd0);
        check("np1_addr", 64'(px_addr_b), 64'd0);
        step();
        check("np1_done_pulse_width", 64'(fd_b), 64'd0);
        check("np1_busy_after", 64'(fb_b), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
